// File: rtl/aec_pkg.sv
// rtl/aec_pkg.sv - aec_tx shared constants: token codes, ASCII glyphs, FSM states
package aec_pkg;

   localparam logic [4:0] TOK_LPAR = 5'd16;
   localparam logic [4:0] TOK_RPAR = 5'd17;
   localparam logic [4:0] TOK_MUL  = 5'd18;
   localparam logic [4:0] TOK_ADD  = 5'd19;
   localparam logic [4:0] TOK_SUB  = 5'd20;

   localparam logic [7:0] ASC_NUL  = 8'd0;
   localparam logic [7:0] ASC_LPAR = 8'd40;
   localparam logic [7:0] ASC_RPAR = 8'd41;
   localparam logic [7:0] ASC_MUL  = 8'd42;
   localparam logic [7:0] ASC_ADD  = 8'd43;
   localparam logic [7:0] ASC_SUB  = 8'd45;
   localparam logic [7:0] ASC_0    = 8'd48;
   localparam logic [7:0] ASC_EQ   = 8'd61;
   localparam logic [7:0] ASC_A    = 8'd97;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      TERM = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

   // Codes above '-' have no character and are refused at load time.
   function automatic logic tokLegal(input logic [4:0] t);
      return (t <= TOK_SUB);
   endfunction

endpackage

// File: rtl/aec_tx_if.sv
// rtl/aec_tx_if.sv - aec_tx host and calculator signal bundle
interface aec_tx_if;
   logic       tok_wr;
   logic [4:0] tok_data;
   logic       clear;
   logic       start;
   logic [7:0] ascii_out;
   logic       ready;
   logic       valid_in;
   logic [6:0] result_in;
   logic       legal_in;
   logic       busy;
   logic       done;
   logic [6:0] resp_result;
   logic       resp_legal;
   logic       timeout;
   logic       err;
   logic [4:0] tok_cnt;
   logic       mismatch;

   modport master (
      output tok_wr, tok_data, clear, start, valid_in, result_in, legal_in,
      input  ascii_out, ready, busy, done, resp_result, resp_legal, timeout, err, tok_cnt, mismatch
   );

   modport slave (
      input  tok_wr, tok_data, clear, start, valid_in, result_in, legal_in,
      output ascii_out, ready, busy, done, resp_result, resp_legal, timeout, err, tok_cnt, mismatch
   );
endinterface

// File: rtl/aec_tok2ascii.sv
// rtl/aec_tok2ascii.sv - combinational 5-bit token to ASCII character map
module aec_tok2ascii
   import aec_pkg::*;
(
   input  logic [4:0] tok,
   output logic [7:0] ascii
);

   logic [4:0] hexOff;

   // Digits land on '0'..'9' and 'a'..'f'; operators on their glyphs; illegal codes give NUL.
   always_comb begin
      hexOff = tok - 5'd10;
      ascii  = ASC_NUL;
      if (tok < 5'd10) begin
         ascii = ASC_0 + {3'b000, tok};
      end else if (tok < TOK_LPAR) begin
         ascii = ASC_A + {3'b000, hexOff};
      end else begin
         case (tok)
            TOK_LPAR: ascii = ASC_LPAR;
            TOK_RPAR: ascii = ASC_RPAR;
            TOK_MUL:  ascii = ASC_MUL;
            TOK_ADD:  ascii = ASC_ADD;
            TOK_SUB:  ascii = ASC_SUB;
            default:  ascii = ASC_NUL;
         endcase
      end
   end

endmodule

// File: rtl/aec_tx.sv
// rtl/aec_tx.sv - expression transmitter; optional parenthesis cross-check under AEC_TX_PARCHECK_EN
module aec_tx
   import aec_pkg::*;
#(
   parameter int DEPTH   = 16,   // at most 16: tok_cnt is 5 bits
   parameter int TIMEOUT = 255
)(
   input logic     clk,
   input logic     rst,
   aec_tx_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT + 1);

   state_t        state, stateNext;
   logic [4:0]    tokBuf [DEPTH];
   logic [4:0]    tokCnt;
   logic [AW-1:0] sendIdx;
   logic [WW-1:0] waitCnt;
   logic [6:0]    respResult;
   logic          respLegal;
   logic          timeoutFlag;
   logic          errFlag;
   logic [4:0]    curTok;
   logic [7:0]    tokAscii;

   logic isIdle, cmdClear, cmdStart, cmdWrite;
   logic bufFull, wrAccept, startOk, lastTok, waitExpire;

   // Host commands are only seen in IDLE; clear beats start, start beats a write.
   assign isIdle     = (state == IDLE);
   assign cmdClear   = isIdle && bus.clear;
   assign cmdStart   = isIdle && !bus.clear && bus.start;
   assign cmdWrite   = isIdle && !bus.clear && !bus.start && bus.tok_wr;
   assign bufFull    = (tokCnt >= 5'(DEPTH));
   assign wrAccept   = cmdWrite && !bufFull && tokLegal(bus.tok_data);
   assign startOk    = cmdStart && (tokCnt != 5'd0);
   assign lastTok    = (5'(sendIdx) == (tokCnt - 5'd1));
   assign waitExpire = (waitCnt == WW'(TIMEOUT - 1));
   assign curTok     = tokBuf[sendIdx];

   // Token storage; contents are don't-care after reset so it carries no reset term.
   always_ff @(posedge clk) begin
      if (wrAccept) tokBuf[tokCnt[AW-1:0]] <= bus.tok_data;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // FSM next state: IDLE -> SEND (n cycles) -> TERM -> WAIT -> DONE -> IDLE.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (startOk) stateNext = SEND;
         SEND:    if (lastTok) stateNext = TERM;
         TERM:    stateNext = WAIT;
         WAIT:    if (bus.valid_in || waitExpire) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Buffer count, sticky flags, send/wait counters and response capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tokCnt      <= '0;
         sendIdx     <= '0;
         waitCnt     <= '0;
         respResult  <= '0;
         respLegal   <= 1'b0;
         timeoutFlag <= 1'b0;
         errFlag     <= 1'b0;
      end else begin
         if (cmdClear) begin
            tokCnt  <= '0;
            errFlag <= 1'b0;
         end else if (cmdStart && !startOk) begin
            errFlag <= 1'b1;
         end else if (cmdWrite && !wrAccept) begin
            errFlag <= 1'b1;
         end
         if (wrAccept) tokCnt <= tokCnt + 5'd1;

         if (startOk) begin
            timeoutFlag <= 1'b0;
            sendIdx     <= '0;
         end else if (state == SEND) begin
            sendIdx <= sendIdx + AW'(1);
         end

         if (state == TERM)      waitCnt <= '0;
         else if (state == WAIT) waitCnt <= waitCnt + WW'(1);

         // A strobe on the expiry cycle still counts as a response.
         if (state == WAIT) begin
            if (bus.valid_in) begin
               respResult <= bus.result_in;
               respLegal  <= bus.legal_in;
            end else if (waitExpire) begin
               timeoutFlag <= 1'b1;
            end
         end
      end
   end

   aec_tok2ascii u_tok2ascii (
      .tok   (curTok),
      .ascii (tokAscii)
   );

   // Outputs decode from state so an async reset clears them on the same edge.
   assign bus.ascii_out   = (state == SEND) ? tokAscii :
                            (state == TERM) ? ASC_EQ   : ASC_NUL;
   assign bus.ready       = (state == SEND) && (sendIdx == '0);
   assign bus.busy        = !isIdle;
   assign bus.done        = (state == DONE);
   assign bus.resp_result = respResult;
   assign bus.resp_legal  = respLegal;
   assign bus.timeout     = timeoutFlag;
   assign bus.err         = errFlag;
   assign bus.tok_cnt     = tokCnt;

`ifdef AEC_TX_PARCHECK_EN
   localparam logic signed [AW+1:0] ONE = 1;

   logic signed [AW+1:0] depth, depthNext;
   logic                 negSeen;
   logic                 mismatchFlag;
   logic                 expLegal;

   // Running parenthesis depth after the token currently on the wire.
   always_comb begin
      depthNext = depth;
      if (curTok == TOK_LPAR)      depthNext = depth + ONE;
      else if (curTok == TOK_RPAR) depthNext = depth - ONE;
   end

   assign expLegal = (depth == '0) && !negSeen;

   // Track depth while sending and compare against the calculator's verdict on capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         depth        <= '0;
         negSeen      <= 1'b0;
         mismatchFlag <= 1'b0;
      end else if (startOk) begin
         depth        <= '0;
         negSeen      <= 1'b0;
         mismatchFlag <= 1'b0;
      end else if (state == SEND) begin
         depth <= depthNext;
         if (depthNext[AW+1]) negSeen <= 1'b1;
      end else if ((state == WAIT) && bus.valid_in) begin
         mismatchFlag <= (bus.legal_in != expLegal);
      end
   end

   assign bus.mismatch = mismatchFlag;
`else
   assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_aec_tx.sv
// tb/tb_aec_tx.sv - randomized self-checking bench for aec_tx
module tb_aec_tx;

   localparam int DEPTH = 16;
   localparam int TO    = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   aec_tx_if bus();

   aec_tx #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [4:0] tokQ [$];
   logic [6:0] expResult;
   logic       expLegal;
   logic       expTimeout;
   logic       expErr;
   logic       expMis;

   function automatic logic [7:0] ascii_of(input logic [4:0] t);
      if (t < 5'd10) return 8'(48 + int'(t));
      if (t < 5'd16) return 8'(97 + int'(t) - 10);
      case (t)
         5'd16:   return 8'd40;
         5'd17:   return 8'd41;
         5'd18:   return 8'd42;
         5'd19:   return 8'd43;
         5'd20:   return 8'd45;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic par_legal();
      int d;
      bit neg;
      d = 0;
      neg = 0;
      foreach (tokQ[i]) begin
         if (tokQ[i] == 5'd16) d++;
         else if (tokQ[i] == 5'd17) d--;
         if (d < 0) neg = 1;
      end
      return (d == 0) && !neg;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.tok_wr   = 1'b0;
      bus.clear    = 1'b0;
      bus.start    = 1'b0;
      bus.valid_in = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      tokQ.delete();
      expErr = 1'b0;
   endtask

   task automatic load(input logic [4:0] t);
      bus.tok_wr   = 1'b1;
      bus.tok_data = t;
      tick();
      bus.tok_wr   = 1'b0;
      if (t > 5'd20 || tokQ.size() >= DEPTH) expErr = 1'b1;
      else tokQ.push_back(t);
   endtask

   task automatic run_txn(input string tag, input bit respond, input int delay,
                          input logic [6:0] res, input bit leg, input bit noise, input bit wrWithStart);
      int n;
      int doneAt;
      bit captured;
      logic [7:0] want;
      n = tokQ.size();
      captured = respond && (delay < TO);
      doneAt = captured ? delay + 1 : TO;
      bus.start = 1'b1;
      if (wrWithStart) begin
         bus.tok_wr   = 1'b1;
         bus.tok_data = 5'd5;
      end
      tick();
      quiet();
      expTimeout = 1'b0;
      expMis = 1'b0;
      for (int k = 0; k < n; k++) begin
         want = ascii_of(tokQ[k]);
         checks++;
         if (bus.ascii_out !== want) begin
            errors++;
            $display("FAIL %s char%0d ascii_out got %0d want %0d", tag, k, bus.ascii_out, want);
         end
         checks++;
         if (bus.ready !== 1'(k == 0)) begin
            errors++;
            $display("FAIL %s char%0d ready got %0b want %0b", tag, k, bus.ready, (k == 0));
         end
         checks++;
         if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s char%0d busy got %0b want 1", tag, k, bus.busy);
         end
         if (noise) begin
            bus.valid_in  = 1'($urandom_range(0, 1));
            bus.result_in = 7'($urandom);
            bus.legal_in  = 1'($urandom_range(0, 1));
            bus.tok_wr    = 1'($urandom_range(0, 1));
            bus.tok_data  = 5'($urandom);
            bus.clear     = 1'($urandom_range(0, 1));
            bus.start     = 1'($urandom_range(0, 1));
         end
         tick();
      end
      quiet();
      checks++;
      if (bus.ascii_out !== 8'd61 || bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL %s term ascii_out/ready got %0d/%0b want 61/0", tag, bus.ascii_out, bus.ready);
      end
      tick();
      for (int c = 0; c < doneAt; c++) begin
         checks++;
         if (bus.done !== 1'b0 || bus.ascii_out !== 8'd0) begin
            errors++;
            $display("FAIL %s wait%0d done/ascii_out got %0b/%0d want 0/0", tag, c, bus.done, bus.ascii_out);
         end
         if (captured && c == delay) begin
            bus.valid_in  = 1'b1;
            bus.result_in = res;
            bus.legal_in  = leg;
         end
         tick();
         bus.valid_in = 1'b0;
      end
      if (captured) begin
         expResult = res;
         expLegal  = leg;
`ifdef AEC_TX_PARCHECK_EN
         expMis = (leg != par_legal());
`endif
      end else begin
         expTimeout = 1'b1;
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL %s done pulse got %0b want 1", tag, bus.done);
      end
      checks++;
      if (bus.resp_result !== expResult || bus.resp_legal !== expLegal) begin
         errors++;
         $display("FAIL %s response got %0d/%0b want %0d/%0b", tag, bus.resp_result, bus.resp_legal, expResult, expLegal);
      end
      checks++;
      if (bus.timeout !== expTimeout) begin
         errors++;
         $display("FAIL %s timeout got %0b want %0b", tag, bus.timeout, expTimeout);
      end
      checks++;
      if (bus.mismatch !== expMis) begin
         errors++;
         $display("FAIL %s mismatch got %0b want %0b", tag, bus.mismatch, expMis);
      end
      if (respond && !captured) begin
         bus.valid_in  = 1'b1;
         bus.result_in = res ^ 7'h55;
         bus.legal_in  = ~leg;
      end
      tick();
      bus.valid_in = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after done done/busy got %0b/%0b want 0/0", tag, bus.done, bus.busy);
      end
      checks++;
      if (bus.tok_cnt !== 5'(n) || bus.err !== expErr) begin
         errors++;
         $display("FAIL %s after done tok_cnt/err got %0d/%0b want %0d/%0b", tag, bus.tok_cnt, bus.err, n, expErr);
      end
      checks++;
      if (bus.resp_result !== expResult || bus.resp_legal !== expLegal) begin
         errors++;
         $display("FAIL %s late strobe response got %0d/%0b want %0d/%0b", tag, bus.resp_result, bus.resp_legal, expResult, expLegal);
      end
   endtask

   task automatic test_reset();
      quiet();
      bus.tok_data  = 5'd0;
      bus.result_in = 7'd0;
      bus.legal_in  = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      expResult = 7'd0;
      expLegal = 1'b0;
      expTimeout = 1'b0;
      expErr = 1'b0;
      expMis = 1'b0;
      tokQ.delete();
      checks++;
      if (bus.ascii_out !== 8'd0 || bus.ready !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset ascii/ready/done/busy got %0d/%0b/%0b/%0b want 0/0/0/0", bus.ascii_out, bus.ready, bus.done, bus.busy);
      end
      checks++;
      if (bus.resp_result !== 7'd0 || bus.resp_legal !== 1'b0 || bus.timeout !== 1'b0 ||
          bus.err !== 1'b0 || bus.tok_cnt !== 5'd0 || bus.mismatch !== 1'b0) begin
         errors++;
         $display("FAIL reset regs got res=%0d leg=%0b to=%0b err=%0b cnt=%0d mis=%0b want all 0",
                  bus.resp_result, bus.resp_legal, bus.timeout, bus.err, bus.tok_cnt, bus.mismatch);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic_expr();
      do_clear();
      load(5'd3); load(5'd19); load(5'd4); load(5'd18); load(5'd2);
      checks++;
      if (bus.tok_cnt !== 5'd5 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL basic load tok_cnt/err got %0d/%0b want 5/0", bus.tok_cnt, bus.err);
      end
      run_txn("basic", 1'b1, int'($urandom_range(0, 3)), 7'd11, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_paren();
      do_clear();
      load(5'd16); load(5'd16); load(5'd10); load(5'd17);
      run_txn("paren_l0", 1'b1, 2, 7'd3, 1'b0, 1'b0, 1'b0);
      run_txn("paren_l1", 1'b1, 0, 7'd4, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_overflow();
      do_clear();
      for (int i = 0; i < 17; i++) load(5'($urandom_range(0, 20)));
      checks++;
      if (bus.tok_cnt !== 5'd16 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL overflow tok_cnt/err got %0d/%0b want 16/1", bus.tok_cnt, bus.err);
      end
      load(5'd25);
      checks++;
      if (bus.err !== 1'b1 || bus.tok_cnt !== 5'd16) begin
         errors++;
         $display("FAIL illegal_full err/tok_cnt got %0b/%0d want 1/16", bus.err, bus.tok_cnt);
      end
      do_clear();
      checks++;
      if (bus.tok_cnt !== 5'd0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL clear tok_cnt/err got %0d/%0b want 0/0", bus.tok_cnt, bus.err);
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL empty_start err/busy got %0b/%0b want 1/0", bus.err, bus.busy);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.ascii_out !== 8'd0) begin
         errors++;
         $display("FAIL empty_start later busy/ascii got %0b/%0d want 0/0", bus.busy, bus.ascii_out);
      end
   endtask

   task automatic test_priority();
      do_clear();
      load(5'd1); load(5'd2);
      bus.clear    = 1'b1;
      bus.tok_wr   = 1'b1;
      bus.tok_data = 5'd7;
      tick();
      quiet();
      tokQ.delete();
      expErr = 1'b0;
      checks++;
      if (bus.tok_cnt !== 5'd0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL clear_vs_wr tok_cnt/err got %0d/%0b want 0/0", bus.tok_cnt, bus.err);
      end
      load(5'd3); load(5'd19); load(5'd4);
      run_txn("start_vs_wr", 1'b1, 1, 7'd7, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_timeout();
      do_clear();
      load(5'd9); load(5'd20); load(5'd15);
      run_txn("timeout", 1'b0, 0, 7'd0, 1'b0, 1'b0, 1'b0);
      run_txn("expiry_valid", 1'b1, TO - 1, 7'd99, 1'b1, 1'b0, 1'b0);
      run_txn("valid_in_done", 1'b1, TO, 7'd42, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_resend();
      do_clear();
      load(5'd16); load(5'd7); load(5'd19); load(5'd12); load(5'd17); load(5'd18); load(5'd0);
      run_txn("resend_a", 1'b1, 3, 7'd21, 1'b1, 1'b0, 1'b0);
      run_txn("resend_b", 1'b1, 5, 7'd22, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 8; it++) begin
         do_clear();
         n = int'($urandom_range(1, 18));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) load(5'($urandom_range(21, 31)));
            else load(5'($urandom_range(0, 20)));
         end
         if (tokQ.size() == 0) load(5'd6);
         checks++;
         if (bus.tok_cnt !== 5'(tokQ.size()) || bus.err !== expErr) begin
            errors++;
            $display("FAIL rand%0d load tok_cnt/err got %0d/%0b want %0d/%0b", it, bus.tok_cnt, bus.err, tokQ.size(), expErr);
         end
         run_txn("random", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, TO + 1)),
                 7'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset_mid_send();
      do_clear();
      load(5'd5); load(5'd18); load(5'd11); load(5'd19); load(5'd8);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.ascii_out !== 8'd0 || bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid ascii/ready/busy got %0d/%0b/%0b want 0/0/0", bus.ascii_out, bus.ready, bus.busy);
      end
      checks++;
      if (bus.tok_cnt !== 5'd0 || bus.err !== 1'b0 || bus.done !== 1'b0 || bus.resp_result !== 7'd0) begin
         errors++;
         $display("FAIL rst_mid regs cnt/err/done/res got %0d/%0b/%0b/%0d want 0/0/0/0",
                  bus.tok_cnt, bus.err, bus.done, bus.resp_result);
      end
      tick();
      rst = 1'b1;
      tokQ.delete();
      expErr = 1'b0;
      expResult = 7'd0;
      expLegal = 1'b0;
      tick();
      load(5'd1); load(5'd19); load(5'd1);
      run_txn("post_rst", 1'b1, 0, 7'd2, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_expr();
      test_paren();
      test_overflow();
      test_priority();
      test_timeout();
      test_resend();
      test_random();
      test_reset_mid_send();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aec_tx.md
Name: aec_tx

Overview:
- Transmitter end of the arithmetic-expression-calculator character interface.
- Host loads an expression as 5-bit token codes into a 16-entry buffer, then pulses start.
- Block serialises the tokens as ASCII, one character per cycle, with a first-character ready pulse and an '=' terminator.
- Block then waits for the calculator's valid pulse and captures the returned result and parentheses-legal flag; used as stimulus/self-check driver and as host-side front end.

Parameters:
- DEPTH, 16, token buffer entries (power of 2).
- TIMEOUT, 255, max cycles in WAIT before abandoning the response.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- tok_wr  in  1  append tok_data to buffer (honoured in IDLE only).
- tok_data  in  5  token: 0-15 hex digit, 16 '(', 17 ')', 18 '*', 19 '+', 20 '-'; 21-31 illegal.
- clear  in  1  empty buffer (IDLE only).
- start  in  1  begin transmission (IDLE only).
- ascii_out  out  8  character to calculator.
- ready  out  1  high exactly on cycle of first character.
- valid_in  in  1  calculator result strobe.
- result_in  in  7  calculator result.
- legal_in  in  1  calculator parentheses-legal flag.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on completion.
- resp_result  out  7  captured result.
- resp_legal  out  1  captured legal flag.
- timeout  out  1  last transaction timed out (sticky until next start).
- err  out  1  sticky: overflow, illegal token, or start with empty buffer; cleared by clear.
- tok_cnt  out  5  tokens held (0..DEPTH).

Behaviour:
- Reset values: ascii_out 8'h00, ready 0, done 0, resp_result 0, resp_legal 0, timeout 0, err 0, tok_cnt 0; state IDLE.
- ascii_out is 8'h00 whenever not sending; it must never show 61 outside TERM.
- ASCII map: digit 0-9 -> 48-57; 10-15 -> 97-102; '(' 40; ')' 41; '*' 42; '+' 43; '-' 45; terminator '=' 61.
- IDLE:
  - tok_wr with tok_cnt<DEPTH and legal code -> store, tok_cnt+1.
  - tok_wr at full, or with illegal code -> dropped, err<=1.
  - clear -> tok_cnt<=0, err<=0; clear wins over a simultaneous tok_wr.
  - start with tok_cnt==0 -> err<=1, stay IDLE.
  - start with tok_cnt>0 -> SEND, timeout<=0. start has priority over tok_wr in the same cycle (write dropped, no err).
- SEND:
  - Start asserted at cycle T: token k is on ascii_out at cycle T+1+k; ready=1 only at T+1.
  - After the last token -> TERM.
- TERM: one cycle, ascii_out=61, then WAIT.
- WAIT:
  - Wait counter starts at 0 and increments each cycle.
  - valid_in -> capture resp_result/resp_legal, go to DONE.
  - Counter reaches TIMEOUT without valid_in -> timeout<=1, go to DONE with captures unchanged.
  - valid_in on the same cycle as expiry counts as a response.
- DONE: done=1 for one cycle, then IDLE.
- valid_in outside WAIT is ignored.
- Inputs tok_wr/clear/start outside IDLE are ignored.
- Buffer contents and tok_cnt persist after DONE, so start resends the same expression.
- Reset asserted mid-transaction aborts immediately to reset values; buffer contents become don't-care.

Optional Feature:
- AEC_TX_PARCHECK_EN.
- Defined:
  - Block keeps a signed depth counter over transmitted tokens: +1 on '(', -1 on ')', with a sticky flag set if depth ever goes negative.
  - exp_legal = (final depth==0 && !neg_flag).
  - Output mismatch (1 bit, reset 0) set on capture when resp_legal != exp_legal; cleared on next start.
- Undefined: no counter; mismatch port present, tied 0.

Decomposition:
- Package aec_pkg holds:
  - token code constants TOK_LPAR..TOK_SUB;
  - ASCII constants (ASC_EQ=61 etc.);
  - state encoding IDLE/SEND/TERM/WAIT/DONE.
- One sub-module, aec_tok2ascii: combinational 5-bit token to 8-bit ASCII map. Shared with future receivers and monitors.

Test Plan:
- Load 3,+(19),4,*(18),2; start at T -> ascii_out 51,43,52,42,50 at T+1..T+5, 61 at T+6, ready only at T+1; valid_in with result_in=11, legal_in=1 -> resp_result=11, resp_legal=1, done pulse.
- Load (,(,a,) = 16,16,10,17; respond legal_in=0 -> ascii 40,40,97,41,61; resp_legal=0; with AEC_TX_PARCHECK_EN, mismatch=0. Respond legal_in=1 instead -> mismatch=1.
- Write 17 tokens -> tok_cnt=16, err=1; then tok_data=25 -> err stays 1; clear -> tok_cnt=0, err=0; start -> err=1, busy stays 0.
- TIMEOUT=8, no valid_in -> done 8 cycles after entering WAIT, timeout=1, resp_result unchanged; valid_in on the expiry cycle -> captured, timeout=0.
- Pulse start again after DONE without reloading -> identical character sequence. Assert rst mid-SEND -> ascii_out=0, ready=0, busy=0 on the same edge.
